prog_seq_n: RTL and testbench

PROG_SEQ_N -- requirements
Module: prog_seq_n

---
 rtl/prog_seq_n.sv | 225 ++++++++++++++++++++++
 tb/tb_prog_seq_n.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_seq_n.sv
// Program sequencer: fetch address generation, jumps, call/return stack and vectored interrupts.
// Define PROG_SEQ_NEST_EN to let a higher-index request preempt a lower in-service channel.
module prog_seq_n #(
    parameter int unsigned AW       = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned NCH      = 4,
    parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           START,
    input  logic [15:0]    RCOMM,
    input  logic [15:0]    SR_IN,
    input  logic [NCH-1:0] IRQ,
    output logic [NCH-1:0] IACK,
    output logic           PM_ENA,
    output logic [AW-2:0]  RAPM,
    output logic [15:0]    SR_OUT,
    output logic           COMME,
    output logic           RTI,
    output logic           STK_OVF,
    output logic           STK_UNF
);
    localparam int unsigned SPW = $clog2(DEPTH) + 1;
    localparam int unsigned EW  = AW + 4;
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, VEC, RUN, EXT} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic [NCH-1:0]   isr_q, isr_d;
    logic [1:0]       ext_q, ext_d;
    logic [15:0]      sr_q, sr_d;
    logic [NCH-1:0]   iack_q, iack_d;
    logic             rti_q, rti_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [EW-1:0]    stk_q [DEPTH];

    logic             push, stk_full;
    logic [EW-1:0]    push_data, top;
    logic [SPW-2:0]   rd_idx;
    logic [3:0]       op, flags;
    logic             halt, is_ret, is_reti, is_call, is_jmp, taken;
    logic [1:0]       ext_n;
    logic [AW-1:0]    joff;
    logic             irq_hit, isr_hit, irq_ok;
    logic [CHW-1:0]   irq_ch, isr_ch;

    assign op       = RCOMM[15:12];
    assign flags    = {SR_IN[8], SR_IN[2], SR_IN[1], SR_IN[0]};
    assign halt     = (RCOMM == 16'h3FFF);
    assign is_ret   = (RCOMM == 16'h4130);
    assign is_reti  = (RCOMM[15:8] == 8'h13);
    assign is_call  = (RCOMM[15:7] == 9'h025);
    assign is_jmp   = (op == 4'd2) || (op == 4'd3);
    assign joff     = {{(AW-11){RCOMM[9]}}, RCOMM[9:0], 1'b0};
    assign stk_full = (sp_q == SPW'(DEPTH));
    assign rd_idx   = sp_q[SPW-2:0] - (SPW-1)'(1);
    assign top      = stk_q[rd_idx];

    always_comb begin
        ext_n = 2'd0;
        if (op > 4'd3 && !is_ret)
            ext_n = {1'b0, RCOMM[7]} + {1'b0, RCOMM[4]};
        else if (op == 4'd1 && RCOMM[11:8] < 4'd2)
            ext_n = {1'b0, RCOMM[4]};
    end

    // RCOMM[12] separates opcode 2 (flag tests) from opcode 3 (signed tests / JMP).
    always_comb begin
        case ({RCOMM[12], RCOMM[11:10]})
            3'b000:  taken = ~SR_IN[1];
            3'b001:  taken =  SR_IN[1];
            3'b010:  taken = ~SR_IN[0];
            3'b011:  taken =  SR_IN[0];
            3'b100:  taken =  SR_IN[2];
            3'b101:  taken = ~(SR_IN[2] ^ SR_IN[8]);
            3'b110:  taken =  SR_IN[2] ^ SR_IN[8];
            default: taken = 1'b1;
        endcase
    end

    always_comb begin
        irq_hit = 1'b0;
        irq_ch  = '0;
        isr_hit = 1'b0;
        isr_ch  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (IRQ[i]) begin
                irq_hit = 1'b1;
                irq_ch  = CHW'(i);
            end
            if (isr_q[i]) begin
                isr_hit = 1'b1;
                isr_ch  = CHW'(i);
            end
        end
`ifdef PROG_SEQ_NEST_EN
        irq_ok = irq_hit && (!isr_hit || irq_ch > isr_ch);
`else
        irq_ok = irq_hit && !isr_hit;
`endif
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        isr_d     = isr_q;
        ext_d     = ext_q;
        sr_d      = sr_q;
        iack_d    = '0;
        rti_d     = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        push      = 1'b0;
        push_data = {pc_q + AW'(4), flags};
        if (START) begin
            pc_d    = '1;
            sr_d    = '0;
            ext_d   = '0;
            state_d = VEC;
        end else begin
            case (state_q)
                VEC: begin
                    pc_d    = RCOMM[AW-1:0];
                    state_d = RUN;
                end
                EXT: begin
                    pc_d  = pc_q + AW'(2);
                    ext_d = ext_q - 2'd1;
                    if (ext_q == 2'd1) state_d = RUN;
                end
                RUN: begin
                    sr_d = SR_IN;
                    if (halt) begin
                        pc_d = pc_q;
                    end else if (SR_IN[3] && irq_ok) begin
                        push           = 1'b1;
                        push_data      = {pc_q, flags};
                        isr_d[irq_ch]  = 1'b1;
                        iack_d[irq_ch] = 1'b1;
                        pc_d           = AW'(VEC_BASE) + AW'({irq_ch, 1'b0});
                        state_d        = VEC;
                    end else if (is_ret || is_reti) begin
                        if (sp_q == '0) begin
                            unf_d = 1'b1;
                            pc_d  = pc_q + AW'(2);
                        end else begin
                            sp_d = sp_q - SPW'(1);
                            pc_d = top[EW-1:4];
                            if (is_reti)
                                sr_d = {SR_IN[15:9], top[3], SR_IN[7:3], top[2:0]};
                        end
                        if (is_reti) begin
                            rti_d = 1'b1;
                            if (isr_hit) isr_d[isr_ch] = 1'b0;
                        end
                    end else if (is_call) begin
                        push    = 1'b1;
                        pc_d    = pc_q + AW'(2);
                        state_d = VEC;
                    end else if (is_jmp) begin
                        pc_d = taken ? pc_q + joff : pc_q + AW'(2);
                    end else begin
                        pc_d = pc_q + AW'(2);
                        if (ext_n != 2'd0) begin
                            ext_d   = ext_n;
                            state_d = EXT;
                        end
                    end
                end
                default: ;
            endcase
            if (push) begin
                if (stk_full) ovf_d = 1'b1;
                else          sp_d  = sp_q + SPW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && push && !stk_full)
            stk_q[sp_q[SPW-2:0]] <= push_data;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            pc_q    <= '0;
            sp_q    <= '0;
            isr_q   <= '0;
            ext_q   <= '0;
            sr_q    <= '0;
            iack_q  <= '0;
            rti_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            PM_ENA  <= 1'b0;
            COMME   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            isr_q   <= isr_d;
            ext_q   <= ext_d;
            sr_q    <= sr_d;
            iack_q  <= iack_d;
            rti_q   <= rti_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            PM_ENA  <= (state_d != IDLE);
            COMME   <= (state_d == RUN);
        end
    end

    assign RAPM    = pc_q[AW-1:1];
    assign SR_OUT  = sr_q;
    assign IACK    = iack_q;
    assign RTI     = rti_q;
    assign STK_OVF = ovf_q;
    assign STK_UNF = unf_q;

endmodule

// File: tb/tb_prog_seq_n.sv
// Directed bench for prog_seq_n: table of single-cycle RUN instructions plus hand-written
// sequences for start-up, extension words, interrupts, nesting and stack limits.
module tb_prog_seq_n;
    logic        CLK, RESET, START;
    logic [15:0] RCOMM, SR_IN, SR_OUT;
    logic [3:0]  IRQ, IACK;
    logic        PM_ENA, COMME, RTI, STK_OVF, STK_UNF;
    logic [14:0] RAPM;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] rcomm;
        logic [15:0] sr;
        logic [15:0] pc;
    } vec_t;
    vec_t tbl [13];

    prog_seq_n #(.AW(16), .DEPTH(8), .NCH(4), .VEC_BASE(16'hFFE0)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .RCOMM(RCOMM), .SR_IN(SR_IN),
        .IRQ(IRQ), .IACK(IACK), .PM_ENA(PM_ENA), .RAPM(RAPM), .SR_OUT(SR_OUT),
        .COMME(COMME), .RTI(RTI), .STK_OVF(STK_OVF), .STK_UNF(STK_UNF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_at_c000();
        START = 1'b1;
        RCOMM = 16'hC000;
        step();
        START = 1'b0;
        step();
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; RCOMM = '0; SR_IN = '0; IRQ = '0;
        tbl[0]  = '{16'h4404, 16'h0000, 16'hC002};
        tbl[1]  = '{16'h2404, 16'h0000, 16'hC004};
        tbl[2]  = '{16'h2C06, 16'h0001, 16'hC010};
        tbl[3]  = '{16'h23FE, 16'h0000, 16'hC00C};
        tbl[4]  = '{16'h3C02, 16'h0000, 16'hC010};
        tbl[5]  = '{16'h3004, 16'h0000, 16'hC012};
        tbl[6]  = '{16'h3004, 16'h0004, 16'hC01A};
        tbl[7]  = '{16'h3404, 16'h0104, 16'hC022};
        tbl[8]  = '{16'h3804, 16'h0100, 16'hC02A};
        tbl[9]  = '{16'h2804, 16'h0001, 16'hC02C};
        tbl[10] = '{16'h3FFF, 16'h0000, 16'hC02C};
        tbl[11] = '{16'h1004, 16'h0000, 16'hC02E};
        tbl[12] = '{16'h3BFF, 16'h0004, 16'hC02C};

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_rapm", 32'(RAPM), 32'h0);
        chk("rst_pm_ena", 32'(PM_ENA), 32'h0);
        chk("rst_comme", 32'(COMME), 32'h0);
        chk("rst_sr_out", 32'(SR_OUT), 32'h0);
        chk("rst_iack", 32'(IACK), 32'h0);
        chk("rst_flags", 32'({RTI, STK_OVF, STK_UNF}), 32'h0);
        RESET = 1'b0;
        step(); step();
        chk("idle_pm_ena", 32'(PM_ENA), 32'h0);

        START = 1'b1; RCOMM = 16'hC000; SR_IN = 16'h0003;
        step();
        START = 1'b0;
        chk("start_rapm", 32'(RAPM), 32'h7FFF);
        chk("start_pm_ena", 32'(PM_ENA), 32'h1);
        chk("start_sr_out", 32'(SR_OUT), 32'h0);
        chk("start_comme", 32'(COMME), 32'h0);
        step();
        chk("vec_rapm", 32'(RAPM), 32'h6000);
        chk("vec_comme", 32'(COMME), 32'h1);

        for (int i = 0; i < 13; i++) begin
            RCOMM = tbl[i].rcomm;
            SR_IN = tbl[i].sr;
            step();
            chk($sformatf("tbl%0d_rapm", i), 32'(RAPM), 32'(tbl[i].pc[15:1]));
            chk($sformatf("tbl%0d_comme", i), 32'(COMME), 32'h1);
            chk($sformatf("tbl%0d_sr_out", i), 32'(SR_OUT), 32'(tbl[i].sr));
        end

        // two extension words at C02C, IRQ[1] raised while in EXT
        RCOMM = 16'h4090; SR_IN = 16'h0008;
        step();
        chk("ext0_rapm", 32'(RAPM), 32'(16'hC02E >> 1));
        chk("ext0_comme", 32'(COMME), 32'h0);
        IRQ = 4'b0010;
        step();
        chk("ext1_rapm", 32'(RAPM), 32'(16'hC030 >> 1));
        chk("ext1_iack", 32'(IACK), 32'h0);
        RCOMM = 16'h4404; SR_IN = 16'h010D;
        step();
        chk("ext2_rapm", 32'(RAPM), 32'(16'hC032 >> 1));
        chk("ext2_iack", 32'(IACK), 32'h0);
        chk("ext2_comme", 32'(COMME), 32'h1);
        step();
        chk("irq1_iack", 32'(IACK), 32'h2);
        chk("irq1_rapm", 32'(RAPM), 32'(16'hFFE2 >> 1));
        IRQ = 4'b0000; RCOMM = 16'hD000;
        step();
        chk("irq1_vec_rapm", 32'(RAPM), 32'(16'hD000 >> 1));
        chk("irq1_iack_pulse", 32'(IACK), 32'h0);
        RCOMM = 16'h1300; SR_IN = 16'h0008;
        step();
        chk("reti1_rti", 32'(RTI), 32'h1);
        chk("reti1_rapm", 32'(RAPM), 32'(16'hC032 >> 1));
        chk("reti1_sr_out", 32'(SR_OUT), 32'h010D);
        RCOMM = 16'h4404;
        step();
        chk("reti1_rti_pulse", 32'(RTI), 32'h0);
        chk("reti1_next_rapm", 32'(RAPM), 32'(16'hC034 >> 1));

        // simultaneous IRQ[0] and IRQ[2]: highest index wins
        SR_IN = 16'h000B; IRQ = 4'b0101;
        step();
        chk("arb_iack", 32'(IACK), 32'h4);
        chk("arb_rapm", 32'(RAPM), 32'(16'hFFE4 >> 1));
        chk("arb_comme", 32'(COMME), 32'h0);
        IRQ = 4'b0000; RCOMM = 16'hE000;
        step();
        RCOMM = 16'h1300; SR_IN = 16'h0108;
        step();
        chk("reti2_rti", 32'(RTI), 32'h1);
        chk("reti2_rapm", 32'(RAPM), 32'(16'hC034 >> 1));
        chk("reti2_sr_out", 32'(SR_OUT), 32'h000B);

        // channel 1 in service, IRQ[3] arrives
        RCOMM = 16'h4404; SR_IN = 16'h0008; IRQ = 4'b0010;
        step();
        chk("isr1_iack", 32'(IACK), 32'h2);
        RCOMM = 16'hF000; IRQ = 4'b1000;
        step();
        chk("isr1_vec_iack", 32'(IACK), 32'h0);
        RCOMM = 16'h4404;
        step();
`ifdef PROG_SEQ_NEST_EN
        chk("nest_iack", 32'(IACK), 32'h8);
        chk("nest_rapm", 32'(RAPM), 32'(16'hFFE6 >> 1));
`else
        chk("nonest_iack", 32'(IACK), 32'h0);
        chk("nonest_rapm", 32'(RAPM), 32'(16'hF002 >> 1));
        RCOMM = 16'h1300;
        step();
        chk("nonest_reti_rapm", 32'(RAPM), 32'(16'hC034 >> 1));
        chk("nonest_reti_iack", 32'(IACK), 32'h0);
        RCOMM = 16'h4404;
        step();
        chk("nonest_late_iack", 32'(IACK), 32'h8);
        chk("nonest_late_rapm", 32'(RAPM), 32'(16'hFFE6 >> 1));
`endif
        IRQ = 4'b0000;

        // stack: call/return, then overflow
        RESET = 1'b1; SR_IN = 16'h0000;
        step();
        RESET = 1'b0;
        start_at_c000();
        RCOMM = 16'h1280;
        step();
        chk("call_rapm", 32'(RAPM), 32'(16'hC002 >> 1));
        chk("call_comme", 32'(COMME), 32'h0);
        RCOMM = 16'hA000;
        step();
        chk("call_tgt_rapm", 32'(RAPM), 32'(16'hA000 >> 1));
        RCOMM = 16'h4130;
        step();
        chk("ret_rapm", 32'(RAPM), 32'(16'hC004 >> 1));
        for (int i = 0; i < 9; i++) begin
            RCOMM = 16'h1280;
            step();
            RCOMM = 16'hA000;
            step();
            chk($sformatf("ovf_call%0d", i), 32'(STK_OVF), 32'(i == 8));
        end
        chk("ovf_call_tgt_rapm", 32'(RAPM), 32'(16'hA000 >> 1));
        RCOMM = 16'h4404;
        step();
        chk("ovf_sticky", 32'(STK_OVF), 32'h1);

        RESET = 1'b1;
        step();
        chk("ovf_rst_clear", 32'(STK_OVF), 32'h0);
        RESET = 1'b0;
        start_at_c000();
        RCOMM = 16'h4130;
        step();
        chk("unf_flag", 32'(STK_UNF), 32'h1);
        chk("unf_rapm", 32'(RAPM), 32'(16'hC002 >> 1));
        RCOMM = 16'h4404;
        step();
        chk("unf_sticky", 32'(STK_UNF), 32'h1);
        chk("unf_next_rapm", 32'(RAPM), 32'(16'hC004 >> 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
